// File: rtl/comp_nbit_seq_pkg.sv
// Purpose : shared types and defaults for the sequential N-bit magnitude comparator.
// Latency : n/a (types, constants and a width helper only).
// Backpressure: n/a.
package comp_pkg;

    typedef enum logic {IDLE, CMP} comp_state_t;

    typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_res_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 2;

    // Slice index register width; kept at least 1 bit so NS == 1 still has a legal vector.
    function automatic int idx_width(input int ns);
        return (ns > 1) ? $clog2(ns) : 1;
    endfunction

endpackage

// File: rtl/comp_nbit_seq_slice.sv
// Purpose : combinational compare of one SLICE-bit slice pair, optional MSB flip for signed top slice.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports   : x, y - slice bits of A and B; inv_msb - flip MSB of both (offset binary); res - LT/EQ/GT.
module comp_slice
    import comp_pkg::*;
#(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             inv_msb,
    output cmp_res_t         res
);

    logic [SLICE-1:0] w_msk;
    logic [SLICE-1:0] w_x;
    logic [SLICE-1:0] w_y;

    always_comb begin
        w_msk          = '0;
        w_msk[SLICE-1] = inv_msb;
        // Flipping the sign bit maps two's complement onto an unsigned order.
        w_x = x ^ w_msk;
        w_y = y ^ w_msk;
        if (w_x > w_y)      res = CMP_GT;
        else if (w_x < w_y) res = CMP_LT;
        else                res = CMP_EQ;
    end

endmodule

// File: rtl/comp_nbit_seq.sv
// Purpose : multi-cycle WIDTH-bit magnitude comparator, MSB slice first, early exit on first difference.
// Latency : done k+1 cycles after start is accepted (k = slices examined, 1..NS).
// Backpressure: start is ignored (not queued) while busy; accepted again in the done cycle.
// Ports   : clk, rst_n (async active-low); start/sgn/a/b request; busy/done status;
//           g/e/l result flags and cnt (slices examined), held until the next done.
module comp_nbit_seq
    import comp_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int SLICE = DEF_SLICE,
    localparam int NS    = WIDTH / SLICE,
    localparam int CW    = $clog2(NS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l,
    output logic [CW-1:0]    cnt
);

    localparam int             IW      = idx_width(NS);
    localparam logic [IW-1:0] TOP_IDX = IW'(NS - 1);
    localparam logic [CW-1:0] NS_CNT  = CW'(NS);

    comp_state_t      r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sgn;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_k;
    logic             r_busy;
    logic             r_done;
    logic             r_g;
    logic             r_e;
    logic             r_l;
    logic [CW-1:0]    r_cnt;

    logic [SLICE-1:0] w_xs;
    logic [SLICE-1:0] w_ys;
    logic             w_inv;
    cmp_res_t         w_res;

    assign w_xs  = r_a[int'(r_idx) * SLICE +: SLICE];
    assign w_ys  = r_b[int'(r_idx) * SLICE +: SLICE];
    // Only the slice holding the sign bit needs the offset-binary flip.
    assign w_inv = r_sgn && (r_idx == TOP_IDX);

    comp_slice #(
        .SLICE   (SLICE)
    ) u_slice (
        .x       (w_xs),
        .y       (w_ys),
        .inv_msb (w_inv),
        .res     (w_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sgn   <= 1'b0;
            r_idx   <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_g     <= 1'b0;
            r_e     <= 1'b0;
            r_l     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sgn   <= sgn;
                        r_idx   <= TOP_IDX;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CMP;
                    end
                end
                CMP: begin
                    if (w_res != CMP_EQ) begin
                        r_g     <= (w_res == CMP_GT);
                        r_l     <= (w_res == CMP_LT);
                        r_e     <= 1'b0;
                        r_cnt   <= r_k + 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_idx == '0) begin
                        r_g     <= 1'b0;
                        r_l     <= 1'b0;
                        r_e     <= 1'b1;
                        r_cnt   <= NS_CNT;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                        r_k   <= r_k + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign g    = r_g;
    assign e    = r_e;
    assign l    = r_l;
    assign cnt  = r_cnt;

endmodule
